aes_engine: RTL and testbench
=============================

Name: aes_engine

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only).
- Accepts one 128-bit plaintext block plus a 128-bit key per transaction, computes one round per clock, and delivers the ciphertext with a one-cycle valid pulse.
- Sits behind an input FIFO: the FIFO side presents a block/key and strobes g_gecerli while the engine reports hazir.
- Round keys are expanded on the fly, so no key RAM is needed.

Parameters:
- None. Round count (10) and the round constants are fixed in the package.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- anahtar  input  128  cipher key; [127:120] is key byte 0.
- blok  input  128  plaintext; [127:120] is byte 0 (state column-major: bytes 0..3 form column 0).
- g_gecerli  input  1  input valid; sampled only while hazir=1.
- hazir  output  1  ready/idle, engine can accept a block.
- sifre  output  128  ciphertext, same byte order as blok.
- c_gecerli  output  1  ciphertext valid, one-cycle pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, round counter=0, internal state/round key=0.
  - sifre=0, c_gecerli=0, hazir=1 (hazir asserted while rst high and immediately after).
- States: IDLE, RUN.
- IDLE:
  - hazir=1.
  - On a rising edge with g_gecerli=1:
    - latch state = blok XOR anahtar and round key = anahtar;
    - round counter=1; go to RUN; hazir=0 from that edge.
  - g_gecerli=0 in IDLE: no change.
- RUN:
  - Each edge applies one round with the current round key expanded by one step: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Key step: RotWord, SubWord, XOR Rcon[r]; Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Round 10 omits MixColumns.
  - On the edge completing round 10: sifre=result, c_gecerli=1 for exactly one cycle, hazir=1, state=IDLE.
- Latency: accept edge E; c_gecerli/hazir high after edge E+10; throughput one block per 11 cycles.
- g_gecerli while hazir=0 is ignored; blok/anahtar may change freely during RUN (both captured at accept).
- g_gecerli held high across the completion cycle: a new block is accepted on the edge after hazir rises. c_gecerli still deasserts on that edge.
- sifre holds the last ciphertext until the next completion or reset.
- Reset mid-operation aborts with no c_gecerli and returns to the reset values.
- GF(2^8) arithmetic: xtime = shift left, XOR 0x1b on carry; MixColumns matrix [2 3 1 1] rotated.

Optional Feature:
- Macro: AES_OUT_MASK_EN.
- Defined: sifre is driven to 0 whenever c_gecerli=0, so the ciphertext is visible only during the valid pulse.
- Undefined: sifre holds the last result as above.
- Timing and handshake are identical in both cases.

Decomposition:
- Package aes_pkg: round count constant (10), Rcon table, state/word typedefs (4x4 byte array, 32-bit word), xtime and mix_column functions.
- Sub-module aes_sbox: 8-bit combinational S-box lookup.
  - Instantiated 16x for SubBytes and 4x for SubWord.
  - ShiftRows, MixColumns and key expansion stay inline in aes_engine.

Test Plan:
- Reset: pulse rst -> hazir=1, c_gecerli=0, sifre=0 while and after rst.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, blok 3243f6a8885a308d313198a2e0370734, g_gecerli pulse -> sifre=3925841d02dc09fbdc118597196a0b32 with c_gecerli high exactly 10 cycles after accept edge, one cycle wide.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, blok 00112233445566778899aabbccddeeff -> sifre=69c4e0d86a7b0430d8cdb78070b4c55a.
- Busy input: g_gecerli held high 4 cycles and blok changed during RUN -> single result for the captured block, hazir=0 for 10 cycles.
- Mid-run reset: rst asserted 5 cycles after accept -> no c_gecerli, hazir=1, sifre=0; a subsequent App. B transaction gives the correct ciphertext.
- Back-to-back: g_gecerli held continuously -> results every 11 cycles, each correct. With AES_OUT_MASK_EN, sifre=0 outside the pulses.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, round constants, state/word
// types, and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef logic [7:0]                 aes_byte_t;
    // One column / key word: element 0 is the top byte (row 0).
    typedef logic [0:3][7:0]            aes_word_t;
    // 4x4 byte array indexed [column][row]; element [0][0] sits in bits
    // [127:120], so a 128-bit block maps straight onto it column-major.
    typedef logic [0:3][0:3][7:0]       aes_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_fsm_t;

    // Round constant table, indexed by round number 1..10.
    function automatic aes_byte_t rcon_lookup(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: matrix rows are [2 3 1 1] rotated right.
    function automatic aes_word_t mix_column(input aes_word_t a);
        aes_word_t m;
        m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        return m;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t in_byte,
    output aes_byte_t out_byte
);

    localparam aes_byte_t SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TABLE[in_byte];

endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly alongside the data path.
// Optional AES_OUT_MASK_EN: sifre reads as zero outside the c_gecerli pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | hazir=1, waiting for g_gecerli to latch blok^anahtar
// ST_RUN  | one round per edge; round 10 skips MixColumns and completes
module aes_engine
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] blok,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] sifre,
    output logic         c_gecerli
);

    aes_fsm_t     fsm_q, fsm_d;
    aes_state_t   state_q, state_d;
    aes_state_t   key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sifre_q, sifre_d;
    logic         c_gecerli_q, c_gecerli_d;
    logic         hazir_q, hazir_d;

    aes_state_t   sub_bytes;
    aes_state_t   shift_rows;
    aes_state_t   mix_cols;
    aes_state_t   key_next;
    aes_state_t   round_out;
    aes_word_t    sub_word;
    aes_word_t    key_temp;

    genvar c, r;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            for (r = 0; r < 4; r++) begin : g_row
                aes_sbox u_sbox (
                    .in_byte  (state_q[c][r]),
                    .out_byte (sub_bytes[c][r])
                );
                // Row r rotates left by r columns.
                assign shift_rows[c][r] = sub_bytes[(c + r) % 4][r];
            end
            assign mix_cols[c] = mix_column(shift_rows[c]);
        end

        // SubWord(RotWord(w3)): byte i of the result comes from byte i+1.
        for (r = 0; r < 4; r++) begin : g_key_sbox
            aes_sbox u_sbox (
                .in_byte  (key_q[3][(r + 1) % 4]),
                .out_byte (sub_word[r])
            );
        end
    endgenerate

    // Next round key from the current one; round_q selects the Rcon.
    always_comb begin
        key_temp    = sub_word;
        key_temp[0] = sub_word[0] ^ rcon_lookup(round_q);
        key_next[0] = key_q[0] ^ key_temp;
        key_next[1] = key_q[1] ^ key_next[0];
        key_next[2] = key_q[2] ^ key_next[1];
        key_next[3] = key_q[3] ^ key_next[2];
    end

    // Final round drops MixColumns, then every round adds the new key.
    always_comb begin
        if (round_q == LAST_ROUND) begin
            round_out = shift_rows ^ key_next;
        end else begin
            round_out = mix_cols ^ key_next;
        end
    end

    // Sequencer next-state: accept in IDLE, iterate in RUN, publish on round 10.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        key_d       = key_q;
        round_d     = round_q;
        sifre_d     = sifre_q;
        c_gecerli_d = 1'b0;
        hazir_d     = hazir_q;
        case (fsm_q)
            ST_IDLE: begin
                if (g_gecerli) begin
                    state_d = blok ^ anahtar;
                    key_d   = anahtar;
                    round_d = 4'd1;
                    hazir_d = 1'b0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                key_d   = key_next;
                round_d = round_q + 4'd1;
                if (round_q == LAST_ROUND) begin
                    sifre_d     = round_out;
                    c_gecerli_d = 1'b1;
                    hazir_d     = 1'b1;
                    round_d     = 4'd0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                hazir_d = 1'b1;
                round_d = 4'd0;
            end
        endcase
    end

    // Register all sequencer and datapath state; reset forces idle/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= 4'd0;
            sifre_q     <= '0;
            c_gecerli_q <= 1'b0;
            hazir_q     <= 1'b1;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            sifre_q     <= sifre_d;
            c_gecerli_q <= c_gecerli_d;
            hazir_q     <= hazir_d;
        end
    end

    assign hazir     = hazir_q;
    assign c_gecerli = c_gecerli_q;

`ifdef AES_OUT_MASK_EN
    assign sifre = c_gecerli_q ? sifre_q : 128'd0;
`else
    assign sifre = sifre_q;
`endif

endmodule

// File: tb/tb_aes_engine.sv
// Self-checking bench for aes_engine against a byte-level AES-128 model.
module tb_aes_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] anahtar = '0;
    logic [127:0] blok = '0;
    logic         g_gecerli = 1'b0;
    logic         hazir;
    logic [127:0] sifre;
    logic         c_gecerli;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] last_exp = '0;
    logic [7:0]   sb_tab [0:255];

    localparam logic [127:0] APPB_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_C = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_K   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_P   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_engine dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .blok      (blok),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .sifre     (sifre),
        .c_gecerli (c_gecerli)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a [0:3];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
                    for (int r = 0; r < 4; r++)
                        s[4*c + r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] idle_sifre(input logic [127:0] last);
`ifdef AES_OUT_MASK_EN
        return 128'd0;
`else
        return last;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction; g_gecerli held for `hold` edges, inputs scrambled after accept.
    task automatic do_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp,
                            input int hold, input string tag);
        int n, lat, hz_low, extra;
        logic [127:0] got;
        check({tag, "_rdy"}, 128'(hazir), 128'd1);
        anahtar = k; blok = p; g_gecerli = 1'b1;
        n = -1; lat = -1; hz_low = 0; got = '0;
        while (lat < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (n >= hold - 1) g_gecerli = 1'b0;
            if (hold > 1) begin blok = rand128(); anahtar = rand128(); end
            if (!hazir) hz_low++;
            if (c_gecerli) begin lat = n; got = sifre; end
        end
        g_gecerli = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_busy_cycles"}, 128'(hz_low), 128'd10);
        check({tag, "_sifre"}, got, exp);
        last_exp = exp;
        @(negedge clk);
        check({tag, "_pulse_end"}, 128'(c_gecerli), 128'd0);
        check({tag, "_sifre_after"}, sifre, idle_sifre(exp));
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (c_gecerli) extra++;
        end
        check({tag, "_extra_pulses"}, 128'(extra), 128'd0);
    endtask

    task automatic midrun_reset();
        int pulses;
        anahtar = rand128(); blok = rand128(); g_gecerli = 1'b1;
        @(negedge clk);
        g_gecerli = 1'b0;
        repeat (5) @(negedge clk);
        check("mrst_busy", 128'(hazir), 128'd0);
        rst = 1'b1;
        #1;
        check("mrst_hazir", 128'(hazir), 128'd1);
        check("mrst_cval", 128'(c_gecerli), 128'd0);
        check("mrst_sifre", sifre, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (c_gecerli) pulses++;
        end
        check("mrst_no_pulse", 128'(pulses), 128'd0);
        check("mrst_hazir_after", 128'(hazir), 128'd1);
        check("mrst_sifre_after", sifre, 128'd0);
    endtask

    // g_gecerli held high; a fresh block is presented each time hazir is seen.
    task automatic back_to_back(input int nblk);
        logic [127:0] expq [$];
        logic [127:0] k, p, e;
        int sent, got, last_pulse, n, bad_idle;
        sent = 0; got = 0; last_pulse = -1; n = 0; bad_idle = 0;
        while (got < nblk && n < 200) begin
            if (c_gecerli) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("b2b_sifre", sifre, e);
                    last_exp = e;
                end else begin
                    check("b2b_unexpected_pulse", 128'd1, 128'(expq.size()));
                end
                if (last_pulse >= 0) check("b2b_gap", 128'(n - last_pulse), 128'd11);
                last_pulse = n;
                got++;
            end else if (sifre !== idle_sifre(last_exp)) begin
                bad_idle++;
            end
            if (hazir) begin
                if (sent < nblk) begin
                    k = rand128(); p = rand128();
                    anahtar = k; blok = p; g_gecerli = 1'b1;
                    expq.push_back(aes_ref(k, p));
                    sent++;
                end else begin
                    g_gecerli = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        g_gecerli = 1'b0;
        check("b2b_count", 128'(got), 128'(nblk));
        check("b2b_idle_sifre", 128'(bad_idle), 128'd0);
    endtask

    initial begin
        logic [127:0] k, p;
        build_sbox();
        repeat (2) @(negedge clk);
        check("rst_hazir", 128'(hazir), 128'd1);
        check("rst_cval", 128'(c_gecerli), 128'd0);
        check("rst_sifre", sifre, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_hazir", 128'(hazir), 128'd1);
        check("post_rst_cval", 128'(c_gecerli), 128'd0);
        check("post_rst_sifre", sifre, 128'd0);

        do_block(APPB_K, APPB_P, APPB_C, 1, "appb");
        do_block(C1_K, C1_P, C1_C, 1, "c1");

        k = rand128(); p = rand128();
        do_block(k, p, aes_ref(k, p), 4, "busy");

        for (int i = 0; i < 3; i++) begin
            k = rand128(); p = rand128();
            do_block(k, p, aes_ref(k, p), 1, "rand");
        end

        midrun_reset();
        do_block(APPB_K, APPB_P, APPB_C, 1, "appb_after_rst");

        back_to_back(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
